pr_sched: RTL and testbench

- Shares the single partial-reconfiguration (PR) bitstream channel between NREQ requesters.
- Round-robin arbitration picks one requester per transfer.
- Each transfer is framed as: start marker {4'hD, slot, 8'h00, 16'hBEEF}, the requester's payload words, then end marker {4'hD, slot, 8'h00, 16'hDEAD}.
- After the end marker, the block waits for the target slot's PR_DONE before it grants the channel again.
- Sits between the bitstream sources and the PR_VALID/PR_DATA bus that feeds the per-slot PR controllers.

---
 rtl/pr_sched.sv | 201 ++++++++++++++++++++
 tb/tb_pr_sched.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_sched.sv
// pr_sched: round-robin scheduler for the shared partial-reconfiguration
// bitstream channel. It frames each granted requester's payload with start
// and end markers and then holds the channel until the target slot reports
// PR_DONE or the wait times out.
module pr_sched #(
   parameter int DWIDTH = 32,
   parameter int NREQ   = 4,
   parameter int TMO    = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   REQ,
   input  logic [4*NREQ-1:0] REQ_SLOT,
   output logic [NREQ-1:0]   GNT,
   input  logic              SRC_VALID,
   input  logic [DWIDTH-1:0] SRC_DATA,
   input  logic              SRC_LAST,
   output logic              SRC_READY,
   output logic              PR_VALID,
   output logic [DWIDTH-1:0] PR_DATA,
   input  logic              PR_READY,
   input  logic [15:0]       PR_DONE_VEC,
   output logic              DONE,
   output logic              ERR,
   output logic              BUSY
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TMO);
   localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TMO - 1);

   typedef enum logic [4:0] {
      S_IDLE = 5'b00001,
      S_HDR  = 5'b00010,
      S_DATA = 5'b00100,
      S_TAIL = 5'b01000,
      S_WAIT = 5'b10000
   } state_t;

   // Frame marker: {D, slot, 00, tag}; tag is BEEF for start, DEAD for end.
   function automatic logic [31:0] marker_word(input logic [3:0] slot, input logic [15:0] tag);
      return {4'hD, slot, 8'h00, tag};
   endfunction

   state_t          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [IW-1:0]   win_q, win_d;
   logic [3:0]      slot_q, slot_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            done_q, done_d;
   logic            err_q, err_d;
   logic            busy_q;

   logic [IW-1:0]   pick_s;
   logic            found_s;
   int              arb_idx_s;
   logic [IW-1:0]   rr_next_s;
   logic            done_hit_s;

   // Round-robin search: the lowest offset from rr_q with REQ set wins.
   always_comb begin
      pick_s    = '0;
      found_s   = 1'b0;
      arb_idx_s = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         arb_idx_s = int'(rr_q) + k;
         arb_idx_s = (arb_idx_s >= NREQ) ? (arb_idx_s - NREQ) : arb_idx_s;
         pick_s    = REQ[arb_idx_s] ? IW'(arb_idx_s) : pick_s;
         found_s   = found_s | REQ[arb_idx_s];
      end
   end

   assign rr_next_s  = (win_q == LAST_IDX) ? '0 : (win_q + {{(IW-1){1'b0}}, 1'b1});
   assign done_hit_s = PR_DONE_VEC[slot_q];

   // Next-state and next-register values for the transfer sequencer.
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      win_d   = win_q;
      slot_d  = slot_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found_s) begin
               win_d   = pick_s;
               slot_d  = REQ_SLOT[4*int'(pick_s) +: 4];
               gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
               state_d = S_HDR;
            end else begin
               gnt_d   = '0;
            end
         end
         S_HDR: begin
            if (PR_READY) begin
               state_d = S_DATA;
            end else begin
               state_d = S_HDR;
            end
         end
         S_DATA: begin
            if (SRC_VALID && PR_READY && SRC_LAST) begin
               state_d = S_TAIL;
            end else begin
               state_d = S_DATA;
            end
         end
         S_TAIL: begin
            if (PR_READY) begin
               state_d = S_WAIT;
               cnt_d   = '0;
            end else begin
               state_d = S_TAIL;
            end
         end
         S_WAIT: begin
            // Slot completion beats a coincident timeout.
            if (done_hit_s) begin
               done_d  = 1'b1;
               gnt_d   = '0;
               rr_d    = rr_next_s;
               state_d = S_IDLE;
            end else if (cnt_q == TMO_LAST) begin
               err_d   = 1'b1;
               gnt_d   = '0;
               rr_d    = rr_next_s;
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   // PR bus and source handshake: markers in HDR/TAIL, pass-through in DATA.
   always_comb begin
      PR_VALID  = 1'b0;
      PR_DATA   = '0;
      SRC_READY = 1'b0;
      case (state_q)
         S_HDR: begin
            PR_VALID = 1'b1;
            PR_DATA  = DWIDTH'(marker_word(slot_q, 16'hBEEF));
         end
         S_DATA: begin
            PR_VALID  = SRC_VALID;
            PR_DATA   = SRC_DATA;
            SRC_READY = PR_READY;
         end
         S_TAIL: begin
            PR_VALID = 1'b1;
            PR_DATA  = DWIDTH'(marker_word(slot_q, 16'hDEAD));
         end
         default: begin
            PR_VALID  = 1'b0;
            PR_DATA   = '0;
            SRC_READY = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any frame in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         win_q   <= '0;
         slot_q  <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         win_q   <= win_d;
         slot_q  <= slot_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         busy_q  <= (state_d != S_IDLE);
      end
   end

   assign GNT  = gnt_q;
   assign DONE = done_q;
   assign ERR  = err_q;
   assign BUSY = busy_q;

endmodule

// File: tb/tb_pr_sched.sv
// tb_pr_sched: directed self-checking bench for pr_sched (NREQ=4, TMO=16).
module tb_pr_sched;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  REQ = 4'b0000;
   logic [15:0] REQ_SLOT = 16'h0000;
   logic [3:0]  GNT;
   logic        SRC_VALID = 1'b0;
   logic [31:0] SRC_DATA = 32'h0;
   logic        SRC_LAST = 1'b0;
   logic        SRC_READY;
   logic        PR_VALID;
   logic [31:0] PR_DATA;
   logic        PR_READY = 1'b1;
   logic [15:0] PR_DONE_VEC = 16'h0000;
   logic        DONE, ERR, BUSY;

   pr_sched #(.DWIDTH(32), .NREQ(4), .TMO(16)) dut (
      .clk(clk), .rst(rst), .REQ(REQ), .REQ_SLOT(REQ_SLOT), .GNT(GNT),
      .SRC_VALID(SRC_VALID), .SRC_DATA(SRC_DATA), .SRC_LAST(SRC_LAST),
      .SRC_READY(SRC_READY), .PR_VALID(PR_VALID), .PR_DATA(PR_DATA),
      .PR_READY(PR_READY), .PR_DONE_VEC(PR_DONE_VEC), .DONE(DONE),
      .ERR(ERR), .BUSY(BUSY)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Source model: {last, data} entries, optional gapping, holds until accepted.
   logic [32:0] src_q[$];
   bit          src_gap = 1'b0;
   bit          src_acc;
   int          gctr = 0;
   bit          pend;
   always begin
      @(negedge clk);
      src_acc = SRC_VALID && SRC_READY;
      @(posedge clk);
      #1;
      if (src_acc && src_q.size() > 0) void'(src_q.pop_front());
      gctr++;
      pend = SRC_VALID && !src_acc && (src_q.size() > 0);
      if (!pend) SRC_VALID = (src_q.size() > 0) && (!src_gap || (gctr % 2 == 1));
      if (src_q.size() > 0) {SRC_LAST, SRC_DATA} = src_q[0];
   end

   // PR_READY model: 0 = always ready, 1 = 1,0,0,1 pattern, else never ready.
   int         rdy_mode = 0;
   int         rcnt = 0;
   logic [3:0] rpat = 4'b1001;
   always begin
      @(posedge clk);
      #1;
      rcnt++;
      case (rdy_mode)
         0: PR_READY = 1'b1;
         1: PR_READY = rpat[rcnt % 4];
         default: PR_READY = 1'b0;
      endcase
   end

   // Bus/grant monitor sampled on the falling edge.
   logic [31:0] acc_q[$];
   int          acc_cyc[$];
   logic [3:0]  glog[$];
   int          gaps[$];
   bit          gseen = 1'b0;
   logic [3:0]  gprev = 4'b0000;
   int          zrun = 0;
   bit          hold_prev = 1'b0;
   logic [31:0] hold_data;
   int          done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
   logic [3:0]  gnt_before_done = 4'b0000;
   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
         gprev = 4'b0000;
         zrun = 0;
      end else begin
         if (hold_prev) begin
            check_val("hold_valid", 32'(PR_VALID), 32'd1);
            check_val("hold_data", PR_DATA, hold_data);
         end
         hold_prev = PR_VALID && !PR_READY;
         hold_data = PR_DATA;
         if (PR_VALID && PR_READY) begin
            acc_q.push_back(PR_DATA);
            acc_cyc.push_back(cyc);
         end
         if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
            gnt_before_done = gprev;
         end
         if (ERR) begin
            err_cnt++;
            err_cyc = cyc;
         end
         if (GNT != 4'b0000 && gprev == 4'b0000) begin
            glog.push_back(GNT);
            if (gseen) gaps.push_back(zrun);
            gseen = 1'b1;
            zrun = 0;
         end else if (GNT == 4'b0000) begin
            zrun++;
         end
         gprev = GNT;
      end
   end

   logic [31:0] exp_q[$];

   task automatic clear_logs();
      @(posedge clk);
      #3;
      acc_q.delete(); acc_cyc.delete(); glog.delete(); gaps.delete();
      exp_q.delete();
      gseen = 1'b0;
   endtask

   task automatic check_acc(input string tag);
      check_val({tag, "_count"}, 32'(acc_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++)
         check_val($sformatf("%s_w%0d", tag, i), acc_q[i], exp_q[i]);
   endtask

   task automatic wait_tail(input string tag, output int c);
      int n = 0;
      bit hit = 1'b0;
      while (!hit && n < 80) begin
         @(negedge clk);
         n++;
         hit = PR_VALID && PR_READY && (PR_DATA[15:0] == 16'hDEAD) && (PR_DATA[31:28] == 4'hD);
      end
      check_val({tag, "_seen"}, 32'(hit), 32'd1);
      c = cyc;
      #1;
   endtask

   task automatic wait_done_err(input string tag);
      int n = 0;
      bit hit = 1'b0;
      while (!hit && n < 80) begin
         @(negedge clk);
         n++;
         hit = DONE || ERR;
      end
      check_val({tag, "_seen"}, 32'(hit), 32'd1);
      #1;
   endtask

   task automatic wait_grant(input int n_exp, input string tag);
      int n = 0;
      while (glog.size() < n_exp && n < 200) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_val({tag, "_seen"}, 32'(glog.size()), 32'(n_exp));
   endtask

   task automatic wait_done_cnt(input int target, input string tag);
      int n = 0;
      while (done_cnt < target && n < 300) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_val(tag, 32'(done_cnt), 32'(target));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   int c;
   int base;
   bit hit;
   int n;

   initial begin
      // Reset values
      @(negedge clk);
      check_val("rst_gnt", 32'(GNT), 32'h0);
      check_val("rst_pr_valid", 32'(PR_VALID), 32'h0);
      check_val("rst_pr_data", PR_DATA, 32'h0);
      check_val("rst_src_ready", 32'(SRC_READY), 32'h0);
      check_val("rst_done", 32'(DONE), 32'h0);
      check_val("rst_err", 32'(ERR), 32'h0);
      check_val("rst_busy", 32'(BUSY), 32'h0);
      @(posedge clk);
      #1 rst = 1'b0;

      // 1: single transfer, requester 0 to slot 3
      clear_logs();
      base = done_cnt;
      REQ_SLOT = 16'h0003;
      src_q.push_back({1'b0, 32'hA5A5A5A5});
      src_q.push_back({1'b1, 32'h12345678});
      REQ = 4'b0001;
      @(negedge clk);
      check_val("t1_gnt_pre", 32'(GNT), 32'h0);
      @(negedge clk);
      check_val("t1_gnt", 32'(GNT), 32'h1);
      check_val("t1_busy", 32'(BUSY), 32'h1);
      REQ = 4'b0000;
      wait_tail("t1_tail", c);
      repeat (5) @(posedge clk);
      #1 PR_DONE_VEC = 16'h0008;
      wait_done_err("t1_end");
      check_val("t1_done", 32'(DONE), 32'h1);
      check_val("t1_err", 32'(ERR), 32'h0);
      check_val("t1_gnt_drop", 32'(GNT), 32'h0);
      check_val("t1_gnt_held", 32'(gnt_before_done), 32'h1);
      PR_DONE_VEC = 16'h0000;
      @(negedge clk);
      #1;
      check_val("t1_done_once", 32'(done_cnt), 32'(base + 1));
      check_val("t1_busy_end", 32'(BUSY), 32'h0);
      exp_q = '{32'hD300BEEF, 32'hA5A5A5A5, 32'h12345678, 32'hD300DEAD};
      check_acc("t1_bus");
      if (acc_cyc.size() == 4) check_val("t1_consec", 32'(acc_cyc[3] - acc_cyc[0]), 32'd3);
      else check_val("t1_consec_n", 32'(acc_cyc.size()), 32'd4);

      // 2: backpressure and gapped source, requester 1 to slot 3
      clear_logs();
      base = done_cnt;
      rdy_mode = 1;
      src_gap = 1'b1;
      REQ_SLOT = 16'h0030;
      PR_DONE_VEC = 16'h0008;
      src_q.push_back({1'b0, 32'hA5A5A5A5});
      src_q.push_back({1'b1, 32'h12345678});
      REQ = 4'b0010;
      wait_grant(1, "t2_grant");
      check_val("t2_gnt", 32'(glog[0]), 32'h2);
      REQ = 4'b0000;
      wait_done_cnt(base + 1, "t2_done_cnt");
      exp_q = '{32'hD300BEEF, 32'hA5A5A5A5, 32'h12345678, 32'hD300DEAD};
      check_acc("t2_bus");
      rdy_mode = 0;
      src_gap = 1'b0;
      PR_DONE_VEC = 16'h0000;

      // 3: round-robin over all four requesters from a fresh reset
      do_reset();
      clear_logs();
      base = done_cnt;
      REQ_SLOT = 16'h7654;
      PR_DONE_VEC = 16'hFFFF;
      for (int k = 0; k < 5; k++) src_q.push_back({1'b1, 32'h00001000 + 32'(k)});
      REQ = 4'b1111;
      wait_grant(5, "t3_grants");
      REQ = 4'b0000;
      wait_done_cnt(base + 5, "t3_done_cnt");
      for (int k = 0; k < 5; k++) begin
         check_val($sformatf("t3_order%0d", k), 32'(glog[k]), 32'(4'b0001 << (k % 4)));
         exp_q.push_back({4'hD, 4'(4 + (k % 4)), 8'h00, 16'hBEEF});
         exp_q.push_back(32'h00001000 + 32'(k));
         exp_q.push_back({4'hD, 4'(4 + (k % 4)), 8'h00, 16'hDEAD});
      end
      check_acc("t3_bus");
      check_val("t3_gap_n", 32'(gaps.size()), 32'd4);
      for (int k = 0; k < 4 && k < gaps.size(); k++)
         check_val($sformatf("t3_gap%0d", k), 32'(gaps[k]), 32'd1);

      // 4: timeout on slot A (requester 2), then requester 0 is granted
      clear_logs();
      base = err_cnt;
      REQ_SLOT = 16'h0A01;
      PR_DONE_VEC = 16'hFBFF;
      src_q.push_back({1'b1, 32'hCAFE0001});
      src_q.push_back({1'b1, 32'hCAFE0002});
      REQ = 4'b0101;
      wait_grant(1, "t4_grant1");
      check_val("t4_first", 32'(glog[0]), 32'h4);
      REQ = 4'b0001;
      wait_tail("t4_tail", c);
      n = done_cnt;
      wait_done_err("t4_end");
      check_val("t4_err", 32'(ERR), 32'h1);
      check_val("t4_done", 32'(DONE), 32'h0);
      check_val("t4_gnt_drop", 32'(GNT), 32'h0);
      check_val("t4_err_lat", 32'(err_cyc - c), 32'd17);
      check_val("t4_no_done", 32'(done_cnt), 32'(n));
      wait_grant(2, "t4_grant2");
      check_val("t4_next", 32'(glog[1]), 32'h1);
      REQ = 4'b0000;
      wait_done_cnt(n + 1, "t4_done_cnt");
      check_val("t4_err_cnt", 32'(err_cnt), 32'(base + 1));

      // 5: done arrives in the same cycle the counter hits TMO-1
      clear_logs();
      base = err_cnt;
      REQ_SLOT = 16'h0060;
      PR_DONE_VEC = 16'hFFBF;
      src_q.push_back({1'b1, 32'h5A5A0001});
      REQ = 4'b0010;
      wait_grant(1, "t5_grant");
      check_val("t5_gnt", 32'(glog[0]), 32'h2);
      REQ = 4'b0000;
      wait_tail("t5_tail", c);
      repeat (16) @(posedge clk);
      #1 PR_DONE_VEC = 16'hFFFF;
      wait_done_err("t5_end");
      check_val("t5_done", 32'(DONE), 32'h1);
      check_val("t5_err", 32'(ERR), 32'h0);
      check_val("t5_done_lat", 32'(done_cyc - c), 32'd17);
      check_val("t5_err_cnt", 32'(err_cnt), 32'(base));
      PR_DONE_VEC = 16'h0000;

      // 6: reset after the first payload word, then a fresh transfer
      clear_logs();
      REQ_SLOT = 16'h0C0E;
      src_q.push_back({1'b0, 32'h01020304});
      src_q.push_back({1'b0, 32'h05060708});
      src_q.push_back({1'b1, 32'h090A0B0C});
      REQ = 4'b0100;
      wait_grant(1, "t6_grant");
      check_val("t6_gnt", 32'(glog[0]), 32'h4);
      REQ = 4'b0000;
      hit = 1'b0;
      n = 0;
      while (!hit && n < 40) begin
         @(negedge clk);
         n++;
         hit = PR_VALID && PR_READY && (PR_DATA == 32'h01020304);
      end
      check_val("t6_word1_seen", 32'(hit), 32'd1);
      rdy_mode = 2;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_val("t6_gnt_rst", 32'(GNT), 32'h0);
      check_val("t6_valid_rst", 32'(PR_VALID), 32'h0);
      check_val("t6_busy_rst", 32'(BUSY), 32'h0);
      exp_q = '{32'hDC00BEEF, 32'h01020304};
      check_acc("t6_partial");
      src_q.delete();
      rdy_mode = 0;
      clear_logs();
      base = done_cnt;
      PR_DONE_VEC = 16'h4000;
      src_q.push_back({1'b1, 32'h77770001});
      REQ = 4'b0101;
      wait_grant(1, "t6_regrant");
      check_val("t6_rr_reset", 32'(glog[0]), 32'h1);
      REQ = 4'b0000;
      wait_done_cnt(base + 1, "t6_done_cnt");
      exp_q = '{32'hDE00BEEF, 32'h77770001, 32'hDE00DEAD};
      check_acc("t6_bus");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
